// File: rtl/laser310_pkg.sv
// Shared types and constants for the Laser 310 video-RAM sharing controller.
package laser310_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BANK_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    D_SETUP  = 2'd1,
    D_STROBE = 2'd2,
    D_DONE   = 2'd3
  } share_state_e;

  localparam logic [BANK_W-1:0] BANK_RESET   = 2'b01;
  localparam logic [3:0]        IO_BANK_PORT = 4'b0111;
  localparam logic [ADDR_W-1:0] WINDOW_BASE  = 16'hB800;

  // DMA request payload captured at the start of an access
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dma_cmd_t;

endpackage

// File: rtl/ram_window_decode.sv
// Combinational Z80 decode: RAM window detect, physical address map and bank-port write detect.
module ram_window_decode
  import laser310_pkg::*;
(
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [BANK_W-1:0] bank,
  output logic              win_c,
  output logic              bank_wr_c,
  output logic [ADDR_W-1:0] map_addr_c
);

  // Refresh (both strobes high) and RD_N=WR_N=0 are excluded by the XOR
  assign win_c = !mreq_n && iorq_n && (rd_n ^ wr_n) && (cpu_a >= WINDOW_BASE);

  assign bank_wr_c = !iorq_n && mreq_n && !wr_n && (cpu_a[7:4] == IO_BANK_PORT);

  // 0xC000-0xFFFF is banked; 0xB800-0xBFFF always lands in the bottom 16K
  assign map_addr_c = (cpu_a[15:14] == 2'b11) ? {bank, cpu_a[13:0]}
                                              : {2'b00, cpu_a[13:0]};

endmodule

// File: rtl/ram_share_ctrl.sv
// Shares one SRAM between a Z80 window (zero-latency pass-through) and a DMA port.
module ram_share_ctrl
  import laser310_pkg::*;
(
  input  logic              clk,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] CPU_A,
  input  logic              MREQ_N,
  input  logic              IORQ_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [1:0]        D1D0,
  output logic              WAIT_N,
  output logic              BUF_OE_N,
  output logic [ADDR_W-1:0] RAM_A,
  output logic              RAM_CS_N,
  output logic              RAM_OE_N,
  output logic              RAM_WE_N,
  output logic [DATA_W-1:0] RAM_D_OUT,
  output logic              RAM_D_OE,
  input  logic [DATA_W-1:0] RAM_D_IN,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [BANK_W-1:0] bank
);

  share_state_e      state;
  dma_cmd_t          cmd_q;
  logic [BANK_W-1:0] bank_q;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              d_oe_q;
  logic              cs_n_q;
  logic              oe_n_q;
  logic              we_n_q;

  logic              win;
  logic              bank_wr;
  logic [ADDR_W-1:0] map_addr;

  ram_window_decode u_decode (
    .cpu_a      (CPU_A),
    .mreq_n     (MREQ_N),
    .iorq_n     (IORQ_N),
    .rd_n       (RD_N),
    .wr_n       (WR_N),
    .bank       (bank_q),
    .win_c      (win),
    .bank_wr_c  (bank_wr),
    .map_addr_c (map_addr)
  );

  // DMA sequencer and bank register; SRAM strobes for DMA phases are registered
  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= IDLE;
      cmd_q   <= '0;
      bank_q  <= BANK_RESET;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      d_oe_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      if (bank_wr) bank_q <= D1D0;
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          // A CPU window cycle holds MREQ_N low, so the CPU always wins a tie
          if (dma_req && MREQ_N) begin
            cmd_q.we    <= dma_we;
            cmd_q.addr  <= dma_addr;
            cmd_q.wdata <= dma_wdata;
            cs_n_q      <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            d_oe_q      <= dma_we;
            state       <= D_SETUP;
          end
        end
        D_SETUP: begin
          we_n_q <= !cmd_q.we;
          oe_n_q <= cmd_q.we;
          state  <= D_STROBE;
        end
        D_STROBE: begin
          if (!cmd_q.we) rdata_q <= RAM_D_IN;
          cs_n_q <= 1'b1;
          oe_n_q <= 1'b1;
          we_n_q <= 1'b1;
          d_oe_q <= 1'b0;
          ack_q  <= 1'b1;
          state  <= D_DONE;
        end
        D_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM steering: CPU pass-through in IDLE, registered DMA strobes otherwise
  always_comb begin
    RAM_A    = map_addr;
    RAM_CS_N = 1'b1;
    RAM_OE_N = 1'b1;
    RAM_WE_N = 1'b1;
    BUF_OE_N = 1'b1;
    if (state == IDLE) begin
      if (win) begin
        RAM_CS_N = 1'b0;
        RAM_OE_N = RD_N;
        RAM_WE_N = WR_N;
        BUF_OE_N = 1'b0;
      end
    end else begin
      RAM_A    = cmd_q.addr;
      RAM_CS_N = cs_n_q;
      RAM_OE_N = oe_n_q;
      RAM_WE_N = we_n_q;
    end
  end

  assign WAIT_N    = !(win && (state != IDLE));
  assign RAM_D_OUT = cmd_q.wdata;
  assign RAM_D_OE  = d_oe_q;
  assign dma_ack   = ack_q;
  assign dma_rdata = rdata_q;
  assign bank      = bank_q;

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Bench for ram_share_ctrl: directed scenarios plus randomized CPU/DMA traffic against a cycle model.
module tb_ram_share_ctrl;

  logic        clk;
  logic        reset_i;
  logic [15:0] cpu_a;
  logic        mreq_n, iorq_n, rd_n, wr_n;
  logic [1:0]  d1d0;
  logic        wait_n, buf_oe_n;
  logic [15:0] ram_a;
  logic        ram_cs_n, ram_oe_n, ram_we_n;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic [7:0]  ram_d_in;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [1:0]  bank;

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM chip model driven by the DUT pins, and the reference memory image
  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign ram_d_in = sram[ram_a];

  // Reference state: cycles since DMA accept (0 = no access in flight)
  int         m_phase = 0;
  logic [1:0] m_bank  = 2'b01;
  logic [7:0] m_rdata = 8'h00;
  logic       m_we    = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0] m_wdata = 8'h00;
  int         bus_left = 0;

  ram_share_ctrl dut (
    .clk       (clk),
    .RESET     (reset_i),
    .CPU_A     (cpu_a),
    .MREQ_N    (mreq_n),
    .IORQ_N    (iorq_n),
    .RD_N      (rd_n),
    .WR_N      (wr_n),
    .D1D0      (d1d0),
    .WAIT_N    (wait_n),
    .BUF_OE_N  (buf_oe_n),
    .RAM_A     (ram_a),
    .RAM_CS_N  (ram_cs_n),
    .RAM_OE_N  (ram_oe_n),
    .RAM_WE_N  (ram_we_n),
    .RAM_D_OUT (ram_d_out),
    .RAM_D_OE  (ram_d_oe),
    .RAM_D_IN  (ram_d_in),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .bank      (bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, from the sharing rules
  task automatic model_check();
    logic        win;
    logic [15:0] e_a;
    logic        e_cs, e_oe, e_we, e_buf, e_wait, e_doe, e_ack;
    win = !mreq_n && iorq_n && (rd_n != wr_n) && (cpu_a >= 16'hB800);
    e_a = (cpu_a >= 16'hC000) ? {m_bank, cpu_a[13:0]} : {2'b00, cpu_a[13:0]};
    e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_buf = 1'b1;
    e_wait = 1'b1; e_doe = 1'b0; e_ack = 1'b0;
    if (m_phase == 0) begin
      if (win) begin
        e_cs = 1'b0; e_oe = rd_n; e_we = wr_n; e_buf = 1'b0;
      end
    end else begin
      e_wait = !win;
      if (m_phase == 1) begin
        e_cs = 1'b0; e_a = m_addr; e_doe = m_we;
      end else if (m_phase == 2) begin
        e_cs = 1'b0; e_a = m_addr; e_doe = m_we;
        e_we = !m_we; e_oe = m_we;
      end else begin
        e_ack = 1'b1;
      end
    end
    chk("ram_cs_n",  16'(ram_cs_n),  16'(e_cs));
    chk("ram_oe_n",  16'(ram_oe_n),  16'(e_oe));
    chk("ram_we_n",  16'(ram_we_n),  16'(e_we));
    chk("buf_oe_n",  16'(buf_oe_n),  16'(e_buf));
    chk("wait_n",    16'(wait_n),    16'(e_wait));
    chk("ram_d_oe",  16'(ram_d_oe),  16'(e_doe));
    chk("dma_ack",   16'(dma_ack),   16'(e_ack));
    chk("dma_rdata", 16'(dma_rdata), 16'(m_rdata));
    chk("bank",      16'(bank),      16'(m_bank));
    if (!e_cs) chk("ram_a", ram_a, e_a);
    if (e_doe) chk("ram_d_out", 16'(ram_d_out), 16'(m_wdata));
    if (!ram_cs_n && !ram_we_n && ram_d_oe) sram[ram_a] = ram_d_out;
  endtask

  // Reference state update for the coming clock edge
  task automatic model_advance();
    if (m_phase == 2 && m_we) ref_mem[m_addr] = m_wdata;
    if (reset_i) begin
      m_phase = 0; m_bank = 2'b01; m_rdata = 8'h00;
      m_we = 1'b0; m_addr = 16'h0000; m_wdata = 8'h00;
    end else begin
      if (!iorq_n && mreq_n && !wr_n && (cpu_a[7:4] == 4'h7)) m_bank = d1d0;
      case (m_phase)
        0: if (dma_req && mreq_n) begin
             m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; m_phase = 1;
           end
        1: m_phase = 2;
        2: begin
             if (!m_we) m_rdata = ref_mem[m_addr];
             m_phase = 3;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic new_bus();
    int k;
    k = $urandom_range(0, 9);
    bus_left = $urandom_range(1, 4);
    bus_idle();
    cpu_a = 16'($urandom);
    d1d0  = 2'($urandom);
    if (k >= 3 && k <= 6) begin
      mreq_n = 1'b0;
      if ($urandom_range(0, 3) != 0) cpu_a = 16'hB000 + 16'($urandom_range(0, 16'h4FFF));
      if (k <= 4) rd_n = 1'b0; else wr_n = 1'b0;
    end else if (k == 7) begin
      iorq_n = 1'b0; wr_n = 1'b0;
      if ($urandom_range(0, 1) == 1) cpu_a[7:4] = 4'h7;
    end else if (k == 8) begin
      mreq_n = 1'b0;
    end else if (k == 9) begin
      if ($urandom_range(0, 1) == 1) begin
        mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      end else begin
        iorq_n = 1'b0; rd_n = 1'b0;
      end
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    reset_i = 1'b1; bus_idle(); cpu_a = 16'h0000; d1d0 = 2'b00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
    sample(); advance();
    sample(); reset_i = 1'b0; advance();

    // Reset state
    sample();
    chk("rst_bank", 16'(bank), 16'h0001);
    chk("rst_ack", 16'(dma_ack), 16'h0000);
    chk("rst_rdata", 16'(dma_rdata), 16'h0000);
    chk("rst_cs_n", 16'(ram_cs_n), 16'h0001);
    advance();

    // CPU read in banked area
    cpu_a = 16'hC123; mreq_n = 1'b0; rd_n = 1'b0;
    sample();
    chk("rd_c123_a", ram_a, 16'h4123);
    chk("rd_c123_cs", 16'(ram_cs_n), 16'h0000);
    chk("rd_c123_oe", 16'(ram_oe_n), 16'h0000);
    chk("rd_c123_we", 16'(ram_we_n), 16'h0001);
    bus_idle(); advance();

    // Bank select via port 0x70, then top-of-window read
    cpu_a = 16'h0070; iorq_n = 1'b0; wr_n = 1'b0; d1d0 = 2'b10;
    sample(); advance();
    bus_idle();
    sample();
    chk("bank_after_io", 16'(bank), 16'h0002);
    advance();
    cpu_a = 16'hFFFF; mreq_n = 1'b0; rd_n = 1'b0;
    sample();
    chk("rd_ffff_a", ram_a, 16'hBFFF);
    advance();

    // Window base write and just-below-window read
    rd_n = 1'b1; wr_n = 1'b0; cpu_a = 16'hB800;
    sample();
    chk("wr_b800_a", ram_a, 16'h3800);
    chk("wr_b800_we", 16'(ram_we_n), 16'h0000);
    chk("wr_b800_oe", 16'(ram_oe_n), 16'h0001);
    advance();
    wr_n = 1'b1; rd_n = 1'b0; cpu_a = 16'hB7FF;
    sample();
    chk("rd_b7ff_cs", 16'(ram_cs_n), 16'h0001);
    bus_idle(); advance();

    // DMA write 0x5A to 0x1234
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 8'h5A;
    sample(); advance();
    sample();
    chk("dw_setup_a", ram_a, 16'h1234);
    chk("dw_setup_we", 16'(ram_we_n), 16'h0001);
    chk("dw_setup_doe", 16'(ram_d_oe), 16'h0001);
    advance();
    sample();
    chk("dw_strobe_we", 16'(ram_we_n), 16'h0000);
    chk("dw_strobe_d", 16'(ram_d_out), 16'h005A);
    advance();
    sample();
    chk("dw_ack", 16'(dma_ack), 16'h0001);
    chk("dw_done_we", 16'(ram_we_n), 16'h0001);
    dma_req = 1'b0; advance();
    sample();
    chk("dw_ack_once", 16'(dma_ack), 16'h0000);
    advance();

    // DMA read back
    dma_req = 1'b1; dma_we = 1'b0;
    sample(); advance();
    sample(); advance();
    sample();
    chk("dr_strobe_oe", 16'(ram_oe_n), 16'h0000);
    advance();
    sample();
    chk("dr_ack", 16'(dma_ack), 16'h0001);
    chk("dr_rdata", 16'(dma_rdata), 16'h005A);
    dma_req = 1'b0; advance();

    // CPU read starts during D_SETUP: stalled, then resumed
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h2345;
    sample(); advance();
    sample();
    cpu_a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
    advance();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (wait_n) break;
      cnt++;
      if (dma_ack) dma_req = 1'b0;
      advance();
    end
    chk("stall_cycles", 16'(cnt), 16'h0002);
    chk("resume_cs", 16'(ram_cs_n), 16'h0000);
    chk("resume_a", ram_a, 16'h8000);
    chk("resume_buf", 16'(buf_oe_n), 16'h0000);
    bus_idle(); advance();

    // Coincident request: CPU first, then DMA; reset during strobe aborts
    cpu_a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0777; dma_wdata = 8'hA5;
    sample();
    chk("tie_cpu_a", ram_a, 16'h8000);
    chk("tie_cpu_wait", 16'(wait_n), 16'h0001);
    advance();
    sample();
    chk("tie_cpu_hold_a", ram_a, 16'h8000);
    bus_idle(); advance();
    sample();
    chk("tie_dma_a", ram_a, 16'h0777);
    chk("tie_dma_doe", 16'(ram_d_oe), 16'h0001);
    advance();
    sample();
    chk("tie_strobe_we", 16'(ram_we_n), 16'h0000);
    reset_i = 1'b1; dma_req = 1'b0; advance();
    reset_i = 1'b0;
    sample();
    chk("abort_ack", 16'(dma_ack), 16'h0000);
    chk("abort_cs", 16'(ram_cs_n), 16'h0001);
    chk("abort_bank", 16'(bank), 16'h0001);
    advance();
    sample();
    chk("abort_no_late_ack", 16'(dma_ack), 16'h0000);
    advance();

    // Randomized CPU and DMA traffic
    for (int c = 0; c < 4000; c++) begin
      if (bus_left == 0) new_bus();
      bus_left--;
      if (!dma_req && $urandom_range(0, 5) == 0) begin
        dma_req   = 1'b1;
        dma_we    = 1'($urandom);
        dma_addr  = 16'h4000 + 16'($urandom_range(0, 31));
        dma_wdata = 8'($urandom);
      end
      reset_i = ($urandom_range(0, 299) == 0);
      sample();
      if (m_phase == 3) dma_req = 1'b0;
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
